// File: rtl/sar_scan.sv
// Multi-channel scan / oversampling sequencer in front of the toggle-handshake SAR controller.
// Walks the enabled mux channels, averages 2^osr conversions each and guards the SAR with a watchdog.
module sar_scan #(
  parameter int NBITS   = 10,
  parameter int NCH     = 4,
  parameter int CHW     = 2,
  parameter int OSR_W   = 2,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             f100m_clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic [NCH-1:0]   ch_en,
  input  logic [OSR_W-1:0] osr,
  output logic             sar_soc,
  input  logic             sar_eoc,
  input  logic [NBITS-1:0] sar_code,
  output logic [CHW-1:0]   ch_sel,
  output logic             busy,
  output logic             res_valid,
  output logic [CHW-1:0]   res_ch,
  output logic [NBITS-1:0] res_data,
  output logic             scan_done,
  output logic             err
);

  localparam int ACC_W = NBITS + (1 << OSR_W) - 1;
  localparam int SMP_W = 1 << OSR_W;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [7:0]       SETTLE_LAST = (SETTLE == 0) ? 8'd0 : 8'(SETTLE - 1);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CONV, ST_NEXT} state_t;

  state_t             state_q, state_d;
  logic [NCH-1:0]     mask_q, mask_d;
  logic [OSR_W-1:0]   osr_q, osr_d;
  logic [7:0]         settle_q, settle_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [SMP_W-1:0]   smp_q, smp_d;
  logic               soc_q, soc_d;
  logic [CHW-1:0]     ch_sel_q, ch_sel_d;
  logic               busy_q, busy_d;
  logic               res_valid_q, res_valid_d;
  logic [CHW-1:0]     res_ch_q, res_ch_d;
  logic [NBITS-1:0]   res_data_q, res_data_d;
  logic               scan_done_q, scan_done_d;
  logic               err_q, err_d;
  logic               eoc_q;

  logic               eoc_ev;
  logic [ACC_W-1:0]   acc_sum;
  logic [SMP_W-1:0]   smp_inc;
  logic [SMP_W-1:0]   smp_target;
  logic [CHW-1:0]     lo_in, lo_cap, nxt_ch;
  logic               has_nxt;

  // Descending scan so the final hit is the lowest qualifying channel.
  always_comb begin
    lo_in   = '0;
    lo_cap  = '0;
    nxt_ch  = '0;
    has_nxt = 1'b0;
    for (int unsigned i = NCH; i > 0; i--) begin
      if (ch_en[i-1])  lo_in  = CHW'(i - 1);
      if (mask_q[i-1]) lo_cap = CHW'(i - 1);
      if (mask_q[i-1] && (CHW'(i - 1) > ch_sel_q)) begin
        nxt_ch  = CHW'(i - 1);
        has_nxt = 1'b1;
      end
    end
  end

  always_comb begin
    eoc_ev      = sar_eoc ^ eoc_q;
    acc_sum     = acc_q + ACC_W'(sar_code);
    smp_inc     = smp_q + SMP_W'(1);
    smp_target  = SMP_W'(1) << osr_q;
    state_d     = state_q;
    mask_d      = mask_q;
    osr_d       = osr_q;
    settle_d    = settle_q;
    tmo_d       = tmo_q;
    acc_d       = acc_q;
    smp_d       = smp_q;
    soc_d       = soc_q;
    ch_sel_d    = ch_sel_q;
    busy_d      = busy_q;
    res_valid_d = 1'b0;
    res_ch_d    = res_ch_q;
    res_data_d  = res_data_q;
    scan_done_d = 1'b0;
    err_d       = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && (ch_en != '0)) begin
          mask_d   = ch_en;
          osr_d    = osr;
          err_d    = 1'b0;
          busy_d   = 1'b1;
          ch_sel_d = lo_in;
          settle_d = '0;
          acc_d    = '0;
          smp_d    = '0;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          soc_d   = ~soc_q;
          tmo_d   = '0;
          state_d = ST_CONV;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      ST_CONV: begin
        if (eoc_ev) begin
          acc_d = acc_sum;
          smp_d = smp_inc;
          if (smp_inc < smp_target) begin
            soc_d = ~soc_q;
            tmo_d = '0;
          end else begin
            // Result registered on entry to NEXT so it appears one cycle after the final eoc.
            res_valid_d = 1'b1;
            res_ch_d    = ch_sel_q;
            res_data_d  = NBITS'(acc_sum >> osr_q);
            state_d     = ST_NEXT;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_NEXT: begin
        acc_d    = '0;
        smp_d    = '0;
        settle_d = '0;
        if (has_nxt) begin
          ch_sel_d = nxt_ch;
          state_d  = ST_SETTLE;
        end else begin
          scan_done_d = 1'b1;
          if (cont) begin
            ch_sel_d = lo_cap;
            state_d  = ST_SETTLE;
          end else begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge f100m_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      osr_q       <= '0;
      settle_q    <= '0;
      tmo_q       <= '0;
      acc_q       <= '0;
      smp_q       <= '0;
      soc_q       <= 1'b0;
      ch_sel_q    <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_data_q  <= '0;
      scan_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      osr_q       <= osr_d;
      settle_q    <= settle_d;
      tmo_q       <= tmo_d;
      acc_q       <= acc_d;
      smp_q       <= smp_d;
      soc_q       <= soc_d;
      ch_sel_q    <= ch_sel_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_data_q  <= res_data_d;
      scan_done_q <= scan_done_d;
      err_q       <= err_d;
    end
  end

  // Tracks sar_eoc in reset too, so a toggle arriving during/after reset is absorbed.
  always_ff @(posedge f100m_clk) begin
    eoc_q <= sar_eoc;
  end

  assign sar_soc   = soc_q;
  assign ch_sel    = ch_sel_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_ch    = res_ch_q;
  assign res_data  = res_data_q;
  assign scan_done = scan_done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sar_scan.sv
// Scoreboard bench for sar_scan: a toggle-handshake SAR model answers conversions,
// stimulus pushes expected results, and a negedge monitor pops and compares them.
module tb_sar_scan;

  typedef struct packed {
    logic [1:0] ch;
    logic [9:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic [3:0] ch_en = '0;
  logic [1:0] osr = '0;
  logic       sar_soc;
  logic       sar_eoc = 1'b0;
  logic [9:0] sar_code = '0;
  logic [1:0] ch_sel;
  logic       busy;
  logic       res_valid;
  logic [1:0] res_ch;
  logic [9:0] res_data;
  logic       scan_done;
  logic       err;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   toggles = 0;
  int   nres = 0;
  int   ndone = 0;
  int   last_toggle_cyc = 0;
  int   last_valid_cyc = 0;
  int   manual_req = 0;
  int   manual_done = 0;
  int   pend = 0;
  int   sar_delay = 3;
  bit   withhold = 1'b0;
  bit   use_q = 1'b0;
  logic soc_seen = 1'b0;
  int   code_q[$];
  exp_t exp_q[$];

  sar_scan #(
    .NBITS(10), .NCH(4), .CHW(2), .OSR_W(2), .SETTLE(4), .TIMEOUT(255)
  ) dut (
    .f100m_clk(clk), .rst(rst), .start(start), .cont(cont),
    .ch_en(ch_en), .osr(osr), .sar_soc(sar_soc), .sar_eoc(sar_eoc),
    .sar_code(sar_code), .ch_sel(ch_sel), .busy(busy), .res_valid(res_valid),
    .res_ch(res_ch), .res_data(res_data), .scan_done(scan_done), .err(err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // SAR model: answers each soc toggle sar_delay cycles later unless withheld.
  initial forever begin
    @(posedge clk);
    #1;
    if (manual_req != manual_done) begin
      manual_done = manual_req;
      sar_eoc = ~sar_eoc;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0 && !withhold) begin
        if (use_q) sar_code = (code_q.size() > 0) ? 10'(code_q.pop_front()) : 10'd0;
        else       sar_code = 10'(100 + int'(ch_sel));
        sar_eoc = ~sar_eoc;
      end
    end
    if (sar_soc !== soc_seen) begin
      soc_seen = sar_soc;
      toggles++;
      last_toggle_cyc = cyc;
      pend = withhold ? 0 : sar_delay;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (res_valid === 1'b1) begin
        nres++;
        last_valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got ch=%0d data=%0d expected no result", res_ch, res_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("res_ch", int'(res_ch), int'(e.ch));
          check("res_data", int'(res_data), int'(e.data));
        end
      end
      if (scan_done === 1'b1) ndone++;
    end
  end

  task automatic push_exp(input int ch, input int data);
    exp_t e;
    e.ch   = 2'(ch);
    e.data = 10'(data);
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [3:0] en, input logic [1:0] o, input logic c, output int c0);
    ch_en = en;
    osr   = o;
    cont  = c;
    start = 1'b1;
    c0    = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick(1);
      n++;
    end
    check(name, int'(busy), 0);
    tick(2);
  endtask

  task automatic wait_toggles(input string name, input int target, input int budget);
    int n = 0;
    while (toggles < target && n < budget) begin
      tick(1);
      n++;
    end
    check(name, int'(toggles >= target), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_soc"}, int'(sar_soc), 0);
    check({tag, "_ch_sel"}, int'(ch_sel), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_res_valid"}, int'(res_valid), 0);
    check({tag, "_res_ch"}, int'(res_ch), 0);
    check({tag, "_res_data"}, int'(res_data), 0);
    check({tag, "_scan_done"}, int'(scan_done), 0);
    check({tag, "_err"}, int'(err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1);
  end

  initial begin
    int c0, r0, d0, t0, tt, ecyc, n;

    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(2);

    // Scan of channels 0,1,3 without averaging.
    push_exp(0, 100); push_exp(1, 101); push_exp(3, 103);
    r0 = nres; d0 = ndone;
    do_start(4'b1011, 2'd0, 1'b0, c0);
    check("t1_busy_after_start", int'(busy), 1);
    wait_idle("t1_idle", 2000);
    check("t1_results", nres - r0, 3);
    check("t1_scan_done", ndone - d0, 1);
    check("t1_queue_empty", exp_q.size(), 0);

    // Four-sample average on channel 2: (10+11+12+14)>>2 = 11.
    use_q = 1'b1;
    code_q = '{10, 11, 12, 14};
    push_exp(2, 11);
    t0 = toggles; r0 = nres;
    do_start(4'b0100, 2'd2, 1'b0, c0);
    check("t2_ch_sel_latency", int'(ch_sel), 2);
    wait_idle("t2_idle", 2000);
    check("t2_soc_toggles", toggles - t0, 4);
    check("t2_results", nres - r0, 1);
    use_q = 1'b0;

    // Latency: soc at start+5, eoc 3 later, res_valid at start+9.
    push_exp(0, 100);
    do_start(4'b0001, 2'd0, 1'b0, c0);
    check("t3_ch_sel", int'(ch_sel), 0);
    wait_idle("t3_idle", 2000);
    check("t3_first_soc_cycle", last_toggle_cyc - c0, 5);
    check("t3_res_valid_cycle", last_valid_cyc - c0, 9);

    // Watchdog: SAR never answers.
    withhold = 1'b1;
    r0 = nres; d0 = ndone; t0 = toggles;
    do_start(4'b0001, 2'd0, 1'b0, c0);
    wait_toggles("t4_soc_seen", t0 + 1, 50);
    tt = last_toggle_cyc;
    n = 0;
    while (err !== 1'b1 && n < 400) begin
      tick(1);
      n++;
    end
    ecyc = cyc;
    check("t4_err_set", int'(err), 1);
    check("t4_err_latency", ecyc - tt, 255);
    check("t4_busy_cleared", int'(busy), 0);
    tick(3);
    check("t4_no_result", nres - r0, 0);
    check("t4_no_scan_done", ndone - d0, 0);
    withhold = 1'b0;
    push_exp(0, 100);
    do_start(4'b0001, 2'd0, 1'b0, c0);
    check("t4_err_cleared", int'(err), 0);
    wait_idle("t4_idle", 2000);

    // Continuous mode over channels 0,1 for three scans.
    for (int i = 0; i < 3; i++) begin
      push_exp(0, 100);
      push_exp(1, 101);
    end
    r0 = nres; d0 = ndone;
    do_start(4'b0011, 2'd0, 1'b1, c0);
    n = 0;
    while (ndone < d0 + 2 && n < 2000) begin
      tick(1);
      n++;
    end
    check("t5_two_scans", ndone - d0, 2);
    cont = 1'b0;
    wait_idle("t5_idle", 2000);
    check("t5_results", nres - r0, 6);
    check("t5_scan_done", ndone - d0, 3);
    check("t5_queue_empty", exp_q.size(), 0);

    do_start(4'b0000, 2'd0, 1'b0, c0);
    check("t5_empty_mask_busy", int'(busy), 0);
    tick(2);
    check("t5_empty_mask_busy_later", int'(busy), 0);

    // Reset mid-conversion, then a late eoc toggle.
    withhold = 1'b1;
    r0 = nres; t0 = toggles;
    do_start(4'b0001, 2'd0, 1'b0, c0);
    wait_toggles("t6_soc_seen", t0 + 1, 50);
    tick(2);
    rst = 1'b1;
    tick(1);
    check_reset_outputs("t6_rst");
    rst = 1'b0;
    tick(4);
    manual_req++;
    tick(10);
    check("t6_no_result", nres - r0, 0);
    check("t6_busy", int'(busy), 0);
    check("t6_soc", int'(sar_soc), 0);
    withhold = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
